// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, receiver state encoding and the
// parity helper. The transmitter uses this package too.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_e;

  // Parity bit value a correct transmitter sends for the given data word.
  function automatic logic par_expect(input parity_e p, input logic [7:0] d);
    logic w_x;
    w_x = ^d;
    return (p == PAR_ODD) ? ~w_x : w_x;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset release never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling FSM with a one-deep valid/ready output
// register, parity/frame error flags and an overrun pulse on dropped frames.
//
// state      | meaning
// S_IDLE     | line idle, waiting for rx_s low
// S_START    | half-bit wait, confirm start bit at its centre
// S_DATA     | sample DATA_BITS data bits, LSB first
// S_PARITY   | sample and check the parity bit
// S_STOP     | sample the stop bit, deliver or drop the frame
// S_BRK_WAIT | stop bit was low, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 16,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam int            BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] H_M1    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_M1 = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic [7:0]           w_shift_pad;

  rx_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr_o;
  logic                 r_overrun;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (w_rx_s)
  );

  assign w_shift_pad = 8'(r_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && m_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end

        S_START: begin
          if (r_cnt == H_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_perr  <= 1'b0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == BITS_M1) begin
              r_state <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_perr  <= (w_rx_s != par_expect(PARITY, w_shift_pad));
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == BIT_M1) begin
            r_cnt <= '0;
            // A frame still waiting for the consumer wins; the new one is lost.
            if (!r_valid || m_ready) begin
              r_data   <= r_shift;
              r_perr_o <= r_perr;
              r_ferr_o <= ~w_rx_s;
              r_valid  <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= w_rx_s ? S_IDLE : S_BRK_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BRK_WAIT: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_data       = r_data;
  assign m_valid      = r_valid;
  assign m_parity_err = r_perr_o;
  assign m_frame_err  = r_ferr_o;
  assign overrun      = r_overrun;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a no-parity and an even-parity receiver driven by a
// bit-level serial line model, checked against a queue of expected frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0   = 1'b1, rx1  = 1'b1;
  logic       rdy0  = 1'b1, rdy1 = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, bz0, bz1;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(d0), .m_valid(v0), .m_ready(rdy0),
    .m_parity_err(pe0), .m_frame_err(fe0), .overrun(ov0), .busy(bz0));

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(d1), .m_valid(v1), .m_ready(rdy1),
    .m_parity_err(pe1), .m_frame_err(fe1), .overrun(ov1), .busy(bz1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  frm_t q0[$];
  frm_t q1[$];
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitors: pop the expected frame on each transfer, check holds.
  int         rise0 = 0, rise1 = 0, ovc0 = 0, ovc1 = 0;
  logic       pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
  logic [9:0] ph0 = '0, ph1 = '0;

  always @(negedge clk) begin
    frm_t e;
    if (!rst_n) begin
      pv0 = 0;
    end else begin
      if (v0 && !pv0) rise0 = cyc;
      if (pv0 && !pr0 && v0) chk("hold0", {pe0, fe0, d0}, ph0);
      if (v0 && rdy0) begin
        if (q0.size() == 0) chk("extra_frame0", 1, 0);
        else begin
          e = q0.pop_front();
          chk("data0", d0, e.d);
          chk("perr0", pe0, e.pe);
          chk("ferr0", fe0, e.fe);
        end
      end
      if (ov0) ovc0++;
      pv0 = v0; pr0 = rdy0; ph0 = {pe0, fe0, d0};
    end
  end

  always @(negedge clk) begin
    frm_t e;
    if (!rst_n) begin
      pv1 = 0;
    end else begin
      if (v1 && !pv1) rise1 = cyc;
      if (pv1 && !pr1 && v1) chk("hold1", {pe1, fe1, d1}, ph1);
      if (v1 && rdy1) begin
        if (q1.size() == 0) chk("extra_frame1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("data1", d1, e.d);
          chk("perr1", pe1, e.pe);
          chk("ferr1", fe1, e.fe);
        end
      end
      if (ov1) ovc1++;
      pv1 = v1; pr1 = rdy1; ph1 = {pe1, fe1, d1};
    end
  end

  // Line driver: called at a negedge, holds level b for n clocks.
  task automatic put(input int k, input logic b, input int n);
    if (k == 0) rx0 = b; else rx1 = b;
    repeat (n) @(negedge clk);
  endtask

  int last_t0 = 0;

  task automatic send(input int k, input logic [7:0] d, input logic pbad,
                      input logic stop, input bit push, input int tail);
    frm_t e;
    e.d  = d;
    e.pe = (k == 1) ? pbad : 1'b0;
    e.fe = ~stop;
    if (push) begin
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    last_t0 = cyc + 1;
    put(k, 1'b0, CPB);
    for (int i = 0; i < 8; i++) put(k, d[i], CPB);
    if (k == 1) put(k, (^d) ^ pbad, CPB);
    put(k, stop, CPB);
    if (tail > 0) put(k, 1'b1, tail);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         ov_before, glen, k;
    logic [7:0] rd;
    logic       rpb, rst;

    repeat (3) @(negedge clk);
    chk("rst_out0", {bz0, ov0, fe0, pe0, v0, d0}, 0);
    chk("rst_out1", {bz1, ov1, fe1, pe1, v1, d1}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame and first-frame latency.
    send(0, 8'hA5, 1'b0, 1'b1, 1, 4);
    chk("latency_a5", rise0 - last_t0, 2 + CPB / 2 + 9 * CPB);
    chk("busy_after_a5", bz0, 0);

    // False starts of assorted short widths.
    for (int g = 0; g < 4; g++) begin
      glen = (g == 0) ? 5 : $urandom_range(1, 5);
      put(0, 1'b0, glen);
      repeat (5 - glen) @(negedge clk);
      chk("glitch_busy", bz0, 1);
      put(0, 1'b1, 20);
      chk("glitch_idle", bz0, 0);
    end

    // Even parity with a wrong parity bit.
    send(1, 8'h03, 1'b1, 1'b1, 1, 4);
    chk("latency_par", rise1 - last_t0, 2 + CPB / 2 + 10 * CPB);

    // Low stop bit, line held low (break), then a clean frame.
    send(0, 8'h55, 1'b0, 1'b0, 1, 0);
    put(0, 1'b0, 40);
    chk("brk_busy", bz0, 1);
    put(0, 1'b1, 4);
    chk("brk_exit", bz0, 0);
    send(0, 8'h12, 1'b0, 1'b1, 1, 4);

    // Overrun: consumer stalled across two frames.
    rdy0 = 1'b0;
    ov_before = ovc0;
    send(0, 8'h11, 1'b0, 1'b1, 1, 4);
    send(0, 8'h22, 1'b0, 1'b1, 0, 4);
    chk("ovr_pulses", ovc0 - ov_before, 1);
    chk("ovr_valid", v0, 1);
    chk("ovr_held", d0, 8'h11);
    @(posedge clk);
    #1 rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drained", v0, 0);
    chk("ovr_queue", q0.size(), 0);

    // Reset in the middle of data bit 3.
    b = 8'h7E;
    put(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) put(0, b[i], CPB);
    put(0, b[3], CPB / 2);
    rst_n = 1'b0;
    rx0   = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_out", {bz0, ov0, fe0, pe0, v0, d0}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_idle", bz0, 0);
    send(0, 8'h3C, 1'b0, 1'b1, 1, 4);

    // Random traffic on both receivers.
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 1);
      rd  = 8'($urandom);
      rpb = (k == 1) && ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 5) != 0);
      send(k, rd, rpb, rst, 1, 4 + $urandom_range(0, 6));
      if (k == 0) chk("rnd_lat0", rise0 - last_t0, 2 + CPB / 2 + 9 * CPB);
      else        chk("rnd_lat1", rise1 - last_t0, 2 + CPB / 2 + 10 * CPB);
    end

    repeat (10) @(negedge clk);
    chk("left_q0", q0.size(), 0);
    chk("left_q1", q1.size(), 0);
    chk("final_busy", {bz1, bz0}, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the clk cycles per UART bit; it SHALL be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8, is the data bits per frame; the legal range SHALL be 5..8.
REQ-003 Parameter PARITY, default PAR_NONE, SHALL select none/even/odd parity as a uart_pkg::parity_e value.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on posedge clk.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port rx, input, 1, SHALL carry the serial line, asynchronous to clk, idle high.
REQ-007 Port m_data, output, DATA_BITS, SHALL carry the received byte, LSB = first data bit.
REQ-008 Port m_valid, output, 1, SHALL indicate m_data/m_parity_err/m_frame_err hold an undelivered frame.
REQ-009 Port m_ready, input, 1, SHALL indicate consumer acceptance; a transfer occurs on posedge with m_valid&m_ready.
REQ-010 Port m_parity_err, output, 1, SHALL flag a parity mismatch in the held frame.
REQ-011 Port m_frame_err, output, 1, SHALL flag a stop bit sampled low in the held frame.
REQ-012 Port overrun, output, 1, SHALL pulse for one cycle when a completed frame is dropped.
REQ-013 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s); no logic SHALL use raw rx.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT; bit counter width $clog2(CLKS_PER_BIT), H = CLKS_PER_BIT/2.
REQ-016 IDLE: rx_s==0 SHALL move to START and clear the cycle counter.
REQ-017 START: at counter==H-1 sample rx_s; 1 SHALL be a false start returning to IDLE with no output, 0 SHALL enter DATA with counter cleared.
REQ-018 DATA: each bit SHALL be sampled at counter==CLKS_PER_BIT-1 and shifted in LSB first; after DATA_BITS samples go to PARITY (if enabled) else STOP.
REQ-019 PARITY: sampled at counter==CLKS_PER_BIT-1; mismatch against even/odd XOR of data SHALL set the frame's parity error.
REQ-020 STOP: sampled at counter==CLKS_PER_BIT-1 (mid stop bit); 1 SHALL go to IDLE, 0 SHALL set frame error and go to BRK_WAIT.
REQ-021 BRK_WAIT SHALL remain until rx_s==1, then go to IDLE.
REQ-022 On the STOP sample edge, if m_valid==0 or m_ready==1 in that cycle, data and both error flags SHALL load and m_valid SHALL be 1 after that edge.
REQ-023 If m_valid==1 and m_ready==0 at the STOP sample edge, the new frame SHALL be discarded, held data SHALL be unchanged, and overrun SHALL be 1 for exactly the next cycle.
REQ-024 m_valid SHALL clear after a transfer edge unless a new frame loads on the same edge (REQ-022).
REQ-025 Latency: with t0 the edge where sync stage 1 first captures 0, m_valid SHALL rise after edge t0 + 2 + H + (DATA_BITS + P + 1)*CLKS_PER_BIT, where P is 1 if parity is enabled, else 0.
REQ-026 Held outputs SHALL be stable while m_valid==1 and m_ready==0.

Reset
REQ-027 During rst_n==0: FSM=IDLE, counters=0, sync flops=1, m_data=0, m_valid=0, m_parity_err=0, m_frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, reception SHALL resume at the next start bit with no partial output.

Structure
REQ-029 Package uart_pkg SHALL hold parity_e (PAR_NONE, PAR_EVEN, PAR_ODD) and rx_state_e; uart_pkg is shared with the transmitter.
REQ-030 The synchronizer SHALL be a sub-module uart_sync2 (clk, rst_n, d, q; reset value 1).

Verification
REQ-031 Default params, frame 0xA5 at 16 clk/bit, m_ready=1 -> m_data=0xA5, errors 0, m_valid rises after edge t0+154 for one cycle.
REQ-032 Low glitch of 5 clk on rx -> false start, busy returns 0, m_valid never asserts.
REQ-033 PARITY=PAR_EVEN, 0x03 sent with parity bit 1 -> m_data=0x03, m_parity_err=1, m_frame_err=0.
REQ-034 0x55 with stop bit 0, then rx held low 40 clk, then 0x12 -> first m_frame_err=1 with BRK_WAIT held until rx high; 0x12 received clean.
REQ-035 m_ready=0, frames 0x11 then 0x22 back-to-back -> m_data stays 0x11, overrun pulses 1 cycle, m_ready=1 delivers 0x11 only.
REQ-036 rst_n pulsed low during data bit 3 of 0x7E, then 0x3C sent -> no output for 0x7E; m_data=0x3C.
